// File: rtl/pkt_sink_checker_pkg.sv
// Shared constants and types for the packet sink checker.
// Header offsets are byte positions within the first beat.
package pkt_sink_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  PROTO_UDP      = 8'h11;
    localparam int          OFF_ETYPE      = 12;
    localparam int          OFF_IPLEN      = 16;
    localparam int          OFF_PROTO      = 23;
    localparam int          ETH_HDR_LEN    = 14;

    typedef enum logic [3:0] {
        ERR_NONE    = 4'd0,
        ERR_ETYPE   = 4'd1,
        ERR_PROTO   = 4'd2,
        ERR_KEEP    = 4'd3,
        ERR_PAYLOAD = 4'd4,
        ERR_LEN     = 4'd5
    } err_e;

    typedef enum logic {
        ST_HDR,
        ST_BODY
    } state_e;

    function automatic logic [15:0] sat_add16(
        input logic [15:0] a,
        input logic [15:0] b
    );
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/pkt_sink_checker_if.sv
// AXI-Stream beat bundle between a packet source and the sink checker.
interface pkt_sink_checker_if #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;

    modport master (
        output tdata, tkeep, tvalid, tlast,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tvalid, tlast,
        output tready
    );
endinterface

// File: rtl/pkt_sink_checker_keep_popcount.sv
// Number of valid bytes flagged in a tkeep mask.
module keep_popcount #(
    parameter int KEEP_WIDTH = 64,
    parameter int CNT_WIDTH  = $clog2(KEEP_WIDTH) + 1
) (
    input  logic [KEEP_WIDTH-1:0] keep,
    output logic [CNT_WIDTH-1:0]  cnt
);
    always_comb begin
        cnt = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            cnt = cnt + CNT_WIDTH'(keep[i]);
        end
    end
endmodule

// File: rtl/pkt_sink_checker.sv
// UDP/IPv4 packet sink: throttles tready, checks each packet, keeps stats.
module pkt_sink_checker
    import pkt_sink_pkg::*;
#(
    parameter int         DATA_WIDTH    = 512,
    parameter int         KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter logic [7:0] BP_PATTERN    = 8'hFF,
    parameter bit         CHECK_PAYLOAD = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    pkt_sink_checker_if.slave s_axis,
    output logic              pkt_done,
    output logic              pkt_ok,
    output logic [15:0]       pkt_bytes,
    output logic [3:0]        err_code,
    output logic [31:0]       pkt_count,
    output logic [31:0]       err_count,
    output logic [47:0]       byte_count
);
    localparam int CW = $clog2(KEEP_WIDTH) + 1;

    logic [2:0]  slot_q, slot_d;
    state_e      state_q, state_d;
    logic [15:0] beat_q, beat_d;
    logic [15:0] bytes_q, bytes_d;
    logic [15:0] ip_len_q, ip_len_d;
    err_e        err_q, err_d;
    logic        pkt_done_q, pkt_done_d;
    logic        pkt_ok_q, pkt_ok_d;
    logic [15:0] pkt_bytes_q, pkt_bytes_d;
    err_e        err_code_q, err_code_d;
    logic [31:0] pkt_count_q, pkt_count_d;
    logic [31:0] err_count_q, err_count_d;
    logic [47:0] byte_count_q, byte_count_d;

    logic [CW-1:0] keep_cnt;
    logic          ready;
    logic          accept;
    logic          is_hdr;
    logic [15:0]   etype;
    logic [7:0]    proto;
    logic [15:0]   ip_len_now;
    logic [15:0]   ip_len_use;
    logic [15:0]   bytes_sat;
    logic          len_bad;
    err_e          beat_err;
    err_e          first_err;

    keep_popcount #(
        .KEEP_WIDTH(KEEP_WIDTH),
        .CNT_WIDTH (CW)
    ) u_popcount (
        .keep(s_axis.tkeep),
        .cnt (keep_cnt)
    );

    // Gating with rst keeps the sink closed while reset is held.
    assign ready         = BP_PATTERN[slot_q] & rst;
    assign s_axis.tready = ready;
    assign accept        = s_axis.tvalid & ready;

    always_comb begin
        is_hdr     = (state_q == ST_HDR);
        etype      = {s_axis.tdata[8*OFF_ETYPE +: 8],
                      s_axis.tdata[8*(OFF_ETYPE+1) +: 8]};
        ip_len_now = {s_axis.tdata[8*OFF_IPLEN +: 8],
                      s_axis.tdata[8*(OFF_IPLEN+1) +: 8]};
        proto      = s_axis.tdata[8*OFF_PROTO +: 8];
        ip_len_use = is_hdr ? ip_len_now : ip_len_q;
        bytes_sat  = sat_add16(bytes_q, 16'(keep_cnt));
        len_bad    = ({1'b0, ip_len_use} + 17'(ETH_HDR_LEN))
                     != {1'b0, bytes_sat};

        // Priority order decides which error wins within one beat.
        beat_err = ERR_NONE;
        if (is_hdr && etype != ETHERTYPE_IPV4) begin
            beat_err = ERR_ETYPE;
        end else if (is_hdr && proto != PROTO_UDP) begin
            beat_err = ERR_PROTO;
        end else if (!s_axis.tlast && !(&s_axis.tkeep)) begin
            beat_err = ERR_KEEP;
        end else if (CHECK_PAYLOAD && !is_hdr &&
                     s_axis.tdata != DATA_WIDTH'(beat_q)) begin
            beat_err = ERR_PAYLOAD;
        end else if (s_axis.tlast && len_bad) begin
            beat_err = ERR_LEN;
        end
        first_err = (err_q != ERR_NONE) ? err_q : beat_err;
    end

    always_comb begin
        slot_d       = slot_q + 3'd1;
        state_d      = state_q;
        beat_d       = beat_q;
        bytes_d      = bytes_q;
        ip_len_d     = ip_len_q;
        err_d        = err_q;
        pkt_done_d   = 1'b0;
        pkt_ok_d     = pkt_ok_q;
        pkt_bytes_d  = pkt_bytes_q;
        err_code_d   = err_code_q;
        pkt_count_d  = pkt_count_q;
        err_count_d  = err_count_q;
        byte_count_d = byte_count_q;
        if (accept) begin
            byte_count_d = byte_count_q + 48'(keep_cnt);
            if (s_axis.tlast) begin
                state_d     = ST_HDR;
                beat_d      = '0;
                bytes_d     = '0;
                err_d       = ERR_NONE;
                pkt_done_d  = 1'b1;
                pkt_ok_d    = (first_err == ERR_NONE);
                pkt_bytes_d = bytes_sat;
                err_code_d  = first_err;
                pkt_count_d = pkt_count_q + 32'd1;
                if (first_err != ERR_NONE) begin
                    err_count_d = err_count_q + 32'd1;
                end
            end else begin
                state_d = ST_BODY;
                beat_d  = sat_add16(beat_q, 16'd1);
                bytes_d = bytes_sat;
                err_d   = first_err;
                if (is_hdr) begin
                    ip_len_d = ip_len_now;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            slot_q       <= '0;
            state_q      <= ST_HDR;
            beat_q       <= '0;
            bytes_q      <= '0;
            ip_len_q     <= '0;
            err_q        <= ERR_NONE;
            pkt_done_q   <= 1'b0;
            pkt_ok_q     <= 1'b0;
            pkt_bytes_q  <= '0;
            err_code_q   <= ERR_NONE;
            pkt_count_q  <= '0;
            err_count_q  <= '0;
            byte_count_q <= '0;
        end else begin
            slot_q       <= slot_d;
            state_q      <= state_d;
            beat_q       <= beat_d;
            bytes_q      <= bytes_d;
            ip_len_q     <= ip_len_d;
            err_q        <= err_d;
            pkt_done_q   <= pkt_done_d;
            pkt_ok_q     <= pkt_ok_d;
            pkt_bytes_q  <= pkt_bytes_d;
            err_code_q   <= err_code_d;
            pkt_count_q  <= pkt_count_d;
            err_count_q  <= err_count_d;
            byte_count_q <= byte_count_d;
        end
    end

    assign pkt_done   = pkt_done_q;
    assign pkt_ok     = pkt_ok_q;
    assign pkt_bytes  = pkt_bytes_q;
    assign err_code   = err_code_q;
    assign pkt_count  = pkt_count_q;
    assign err_count  = err_count_q;
    assign byte_count = byte_count_q;
endmodule

// File: tb/tb_pkt_sink_checker.sv
// Bench for pkt_sink_checker: per-packet reference model plus directed cases.
`timescale 1ns/1ps
module tb_pkt_sink_checker;
    localparam int DW = 512;
    localparam int KW = 64;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pkt_sink_checker_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) ifa ();
    pkt_sink_checker_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) ifb ();

    logic        done_a, ok_a, done_b, ok_b;
    logic [15:0] nb_a, nb_b;
    logic [3:0]  ec_a, ec_b;
    logic [31:0] pc_a, erc_a, pc_b, erc_b;
    logic [47:0] bc_a, bc_b;

    pkt_sink_checker #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW),
        .BP_PATTERN(8'hFF), .CHECK_PAYLOAD(1'b1)
    ) dut_a (
        .clk(clk), .rst(rst), .s_axis(ifa),
        .pkt_done(done_a), .pkt_ok(ok_a), .pkt_bytes(nb_a),
        .err_code(ec_a), .pkt_count(pc_a), .err_count(erc_a),
        .byte_count(bc_a)
    );

    pkt_sink_checker #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW),
        .BP_PATTERN(8'b0101_0101), .CHECK_PAYLOAD(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst), .s_axis(ifb),
        .pkt_done(done_b), .pkt_ok(ok_b), .pkt_bytes(nb_b),
        .err_code(ec_b), .pkt_count(pc_b), .err_count(erc_b),
        .byte_count(bc_b)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state, one slot per DUT.
    logic [7:0]  pat [2];
    bit          chk [2];
    bit          live [2];
    int          slot [2];
    beat_t       cur [2][$];
    bit          e_done [2];
    bit          e_ok [2];
    logic [15:0] e_nb [2];
    logic [3:0]  e_ec [2];
    logic [31:0] e_pc [2];
    logic [31:0] e_erc [2];
    logic [47:0] e_bc [2];
    bit          l_ok [2];
    logic [15:0] l_nb [2];
    logic [3:0]  l_ec [2];
    int          l_seen [2];

    beat_t pk[$];

    task automatic cmp(input int id, input string nm,
                       input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL dut%0d %s: got %0h expected %0h at %0t",
                     id, nm, act, exp, $time);
        end
    endtask

    // Judge a complete packet from its beats, in arrival order.
    function automatic void eval_pkt(input int id, output bit ok,
                                     output logic [15:0] nb,
                                     output logic [3:0] ec);
        int n;
        int tot;
        int iplen;
        logic [DW-1:0] d;
        logic [3:0] e;
        n = cur[id].size();
        tot = 0;
        e = 0;
        for (int i = 0; i < n; i++) tot += $countones(cur[id][i].keep);
        if (tot > 65535) tot = 65535;
        d = cur[id][0].data;
        iplen = int'({d[16*8 +: 8], d[17*8 +: 8]});
        for (int i = 0; i < n && e == 0; i++) begin
            d = cur[id][i].data;
            if (i == 0 && {d[12*8 +: 8], d[13*8 +: 8]} != 16'h0800) e = 1;
            else if (i == 0 && d[23*8 +: 8] != 8'h11) e = 2;
            else if (i < n - 1 && cur[id][i].keep != {KW{1'b1}}) e = 3;
            else if (i > 0 && chk[id] &&
                     d != DW'((i > 65535) ? 65535 : i)) e = 4;
            else if (i == n - 1 && iplen + 14 != tot) e = 5;
        end
        ok = (e == 0);
        nb = 16'(tot);
        ec = e;
    endfunction

    task automatic check_step(input int id, input bit rdy, input bit v,
                              input bit last, input logic [DW-1:0] d,
                              input logic [KW-1:0] k, input bit done,
                              input bit ok, input logic [15:0] nb,
                              input logic [3:0] ec, input logic [31:0] pc,
                              input logic [31:0] erc,
                              input logic [47:0] bc);
        bit acc;
        bit m_ok;
        logic [15:0] m_nb;
        logic [3:0] m_ec;
        beat_t b;
        if (live[id]) begin
            cmp(id, "tready", rdy, rst & pat[id][slot[id]]);
            cmp(id, "pkt_done", done, e_done[id]);
            if (e_done[id]) begin
                cmp(id, "pkt_ok", ok, e_ok[id]);
                cmp(id, "pkt_bytes", nb, e_nb[id]);
                cmp(id, "err_code", ec, e_ec[id]);
            end
            cmp(id, "pkt_count", pc, e_pc[id]);
            cmp(id, "err_count", erc, e_erc[id]);
            cmp(id, "byte_count", bc, e_bc[id]);
            if (done) begin
                l_ok[id] = ok;
                l_nb[id] = nb;
                l_ec[id] = ec;
                l_seen[id]++;
            end
        end
        if (!rst) begin
            live[id] = 1'b1;
            slot[id] = 0;
            cur[id].delete();
            e_done[id] = 0;
            e_ok[id] = 0;
            e_nb[id] = 0;
            e_ec[id] = 0;
            e_pc[id] = 0;
            e_erc[id] = 0;
            e_bc[id] = 0;
        end else if (live[id]) begin
            acc = v && pat[id][slot[id]];
            slot[id] = (slot[id] + 1) % 8;
            e_done[id] = 0;
            if (acc) begin
                b.data = d;
                b.keep = k;
                cur[id].push_back(b);
                e_bc[id] = e_bc[id] + 48'($countones(k));
                if (last) begin
                    eval_pkt(id, m_ok, m_nb, m_ec);
                    e_done[id] = 1;
                    e_ok[id] = m_ok;
                    e_nb[id] = m_nb;
                    e_ec[id] = m_ec;
                    e_pc[id] = e_pc[id] + 1;
                    if (!m_ok) e_erc[id] = e_erc[id] + 1;
                    cur[id].delete();
                end
            end
        end
    endtask

    always @(negedge clk) begin
        check_step(0, ifa.tready, ifa.tvalid, ifa.tlast, ifa.tdata,
                   ifa.tkeep, done_a, ok_a, nb_a, ec_a, pc_a, erc_a, bc_a);
        check_step(1, ifb.tready, ifb.tvalid, ifb.tlast, ifb.tdata,
                   ifb.tkeep, done_b, ok_b, nb_b, ec_b, pc_b, erc_b, bc_b);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int id, input bit v, input bit last,
                       input beat_t b);
        if (id == 0) begin
            ifa.tvalid = v; ifa.tlast = last;
            ifa.tdata = b.data; ifa.tkeep = b.keep;
        end else begin
            ifb.tvalid = v; ifb.tlast = last;
            ifb.tdata = b.data; ifb.tkeep = b.keep;
        end
    endtask

    function automatic bit rdy(input int id);
        return (id == 0) ? ifa.tready : ifb.tready;
    endfunction

    task automatic do_reset();
        beat_t z;
        z = '0;
        put(0, 0, 0, z);
        put(1, 0, 0, z);
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
    endtask

    // Sends up to maxb beats of pk with optional idle bubbles.
    task automatic send(input int id, input bit b2b, input int bub,
                        input int maxb);
        bit acc;
        beat_t junk;
        for (int i = 0; i < pk.size() && i < maxb; i++) begin
            while (bub > 0 && $urandom_range(99) < bub) begin
                junk.data = {16{$urandom()}};
                junk.keep = {2{$urandom()}};
                put(id, 0, 0, junk);
                tick();
            end
            put(id, 1, i == pk.size() - 1, pk[i]);
            acc = 0;
            for (int w = 0; w < 64 && !acc; w++) begin
                @(negedge clk);
                acc = rdy(id);
                tick();
            end
            if (!acc) begin
                n_vec++;
                n_miss++;
                $display("FAIL dut%0d handshake: got no tready, need one", id);
            end
        end
        if (!b2b) begin
            junk = '0;
            put(id, 0, 0, junk);
        end
    endtask

    // Builds a packet; lastn = bytes in final beat; -1 disables a fault.
    function automatic void build(input int nb, input int lastn,
                                  input logic [15:0] etype,
                                  input logic [7:0] proto,
                                  input int len_adj, input int bad_pay,
                                  input int bad_keep);
        beat_t b;
        int tot;
        logic [15:0] il;
        pk.delete();
        tot = (nb - 1) * 64 + lastn;
        il = 16'(tot - 14 + len_adj);
        for (int i = 0; i < nb; i++) begin
            if (i == 0) begin
                for (int j = 0; j < 16; j++) b.data[32*j +: 32] = $urandom();
                b.data[12*8 +: 8] = etype[15:8];
                b.data[13*8 +: 8] = etype[7:0];
                b.data[16*8 +: 8] = il[15:8];
                b.data[17*8 +: 8] = il[7:0];
                b.data[23*8 +: 8] = proto;
            end else if (i == bad_pay) begin
                b.data = DW'(i + 5);
            end else begin
                b.data = DW'(i);
            end
            if (i == nb - 1)
                b.keep = (lastn >= 64) ? {KW{1'b1}} : ((64'd1 << lastn) - 1);
            else
                b.keep = {KW{1'b1}};
            if (i == bad_keep) b.keep = {KW{1'b1}} >> 1;
            pk.push_back(b);
        end
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, need $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int np;
        int nbt;
        int f;
        beat_t z;
        pat[0] = 8'hFF; pat[1] = 8'b0101_0101;
        chk[0] = 1'b1;  chk[1] = 1'b0;
        z = '0;
        put(0, 0, 0, z);
        put(1, 0, 0, z);
        do_reset();
        cmp(0, "reset pkt_count", pc_a, 0);
        cmp(0, "reset byte_count", bc_a, 0);
        cmp(1, "reset pkt_done", done_b, 0);

        // 1-beat UDP packet, IP len 50 -> 64 bytes.
        build(1, 64, 16'h0800, 8'h11, 0, -1, -1);
        s = l_seen[0];
        send(0, 0, 0, 99);
        repeat (3) tick();
        cmp(0, "lit1 seen", l_seen[0] - s, 1);
        cmp(0, "lit1 ok", l_ok[0], 1);
        cmp(0, "lit1 bytes", l_nb[0], 64);
        cmp(0, "lit1 pkt_count", pc_a, 1);

        // 4-beat, IP len 242, payload 1..3.
        do_reset();
        build(4, 64, 16'h0800, 8'h11, 0, -1, -1);
        send(0, 0, 0, 99);
        repeat (3) tick();
        cmp(0, "lit2 ok", l_ok[0], 1);
        cmp(0, "lit2 bytes", l_nb[0], 256);
        cmp(0, "lit2 byte_count", bc_a, 256);

        // Beat 2 carries 7 instead of 2.
        do_reset();
        build(4, 64, 16'h0800, 8'h11, 0, 2, -1);
        send(0, 0, 0, 99);
        repeat (3) tick();
        cmp(0, "lit3 ok", l_ok[0], 0);
        cmp(0, "lit3 err", l_ec[0], 4);
        cmp(0, "lit3 err_count", erc_a, 1);

        // Wrong ethertype plus wrong length: ethertype wins.
        do_reset();
        build(1, 64, 16'h86DD, 8'h11, 3, -1, -1);
        send(0, 0, 0, 99);
        repeat (3) tick();
        cmp(0, "lit4 err", l_ec[0], 1);

        build(2, 40, 16'h0800, 8'h06, 0, -1, -1);
        send(0, 0, 0, 99);
        repeat (3) tick();
        cmp(0, "lit5 err", l_ec[0], 2);

        build(3, 64, 16'h0800, 8'h11, 0, -1, 1);
        send(0, 0, 0, 99);
        repeat (3) tick();
        cmp(0, "lit6 err", l_ec[0], 3);

        build(2, 10, 16'h0800, 8'h11, 1, -1, -1);
        send(0, 0, 0, 99);
        repeat (3) tick();
        cmp(0, "lit7 err", l_ec[0], 5);
        cmp(0, "lit7 bytes", l_nb[0], 74);
        cmp(0, "lit7 err_count", erc_a, 4);

        // Reset after two beats of a four-beat packet.
        do_reset();
        build(4, 64, 16'h0800, 8'h11, 0, -1, -1);
        s = l_seen[0];
        send(0, 0, 0, 2);
        do_reset();
        build(1, 48, 16'h0800, 8'h11, 0, -1, -1);
        send(0, 0, 0, 99);
        repeat (3) tick();
        cmp(0, "lit8 seen", l_seen[0] - s, 1);
        cmp(0, "lit8 ok", l_ok[0], 1);
        cmp(0, "lit8 pkt_count", pc_a, 1);

        // Randomized traffic with stalls and injected faults.
        do_reset();
        np = 150;
        for (int p = 0; p < np; p++) begin
            nbt = $urandom_range(1, 5);
            f = $urandom_range(0, 9);
            build(nbt, (nbt == 1) ? $urandom_range(24, 64)
                                  : $urandom_range(1, 64),
                  (f == 1) ? 16'h86DD : 16'h0800,
                  (f == 2) ? 8'h06 : 8'h11,
                  (f == 5) ? int'($urandom_range(1, 9)) : 0,
                  (f == 4 && nbt > 1) ? int'($urandom_range(1, nbt - 1)) : -1,
                  (f == 3 && nbt > 1) ? int'($urandom_range(0, nbt - 2)) : -1);
            send(0, $urandom_range(0, 1), 20, 99);
        end
        put(0, 0, 0, z);
        repeat (3) tick();
        cmp(0, "random pkt_count", pc_a, np);

        // Alternate-slot backpressure, 64 back-to-back 2-beat packets.
        do_reset();
        for (int p = 0; p < 64; p++) begin
            build(2, 64, 16'h0800, 8'h11, 0, 1, -1);
            send(1, 1, 0, 99);
        end
        put(1, 0, 0, z);
        repeat (3) tick();
        cmp(1, "bp pkt_count", pc_b, 64);
        cmp(1, "bp err_count", erc_b, 0);
        cmp(1, "bp byte_count", bc_b, 64 * 128);

        repeat (4) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
